pipe_skid_stage: RTL

Parametrised, flushable pipeline-stage register for the RV32IM pipeline, generalising the fixed EX/MEM latch into a valid/ready stage with a two-entry skid buffer. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), carries an opaque payload of configurable width, absorbs downstream back-pressure without a combinational ready path, and supports a synchronous flush for branch and exception squash. A saturating stall counter provides per-stage back-pressure statistics.

---
 rtl/rv_pipe_pkg.sv | 31 +++
 rtl/pipe_skid_stage.sv | 128 ++++++++++++
 2 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV32IM pipeline-stage registers.
//   stage_state_e : occupancy state of a valid/ready skid stage
//   *_W           : default payload widths at each pipeline boundary
//   occ_of()      : maps a stage state to its entry count
package rv_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  localparam int unsigned IFID_W  = 32'd64;
  localparam int unsigned IDEX_W  = 32'd128;
  localparam int unsigned EXMEM_W = 32'd104;
  localparam int unsigned MEMWB_W = 32'd72;

  // The encoding is chosen so the state value is the entry count,
  // but the explicit mapping keeps that coupling in one place.
  function automatic logic [1:0] occ_of(input stage_state_e st);
    logic [1:0] occ;
    case (st)
      ST_EMPTY: occ = 2'd0;
      ST_ONE:   occ = 2'd1;
      ST_FULL:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// Flushable valid/ready pipeline-stage register with a two-entry skid buffer.
// The main register drives out_data; the skid register catches the one
// payload that arrives while downstream is stalled, so in_ready never
// depends combinationally on out_ready.
// Ports:
//   clk, clrn               clock, asynchronous active-low reset
//   in_valid/in_ready/in_data    upstream handshake and payload
//   out_valid/out_ready/out_data downstream handshake and payload
//   flush                   synchronous squash of all held entries
//   occupancy               entries held (0..2)
//   stall_cnt               saturating count of back-pressured cycles
module pipe_skid_stage
  import rv_pipe_pkg::*;
#(
  parameter int unsigned DATA_W       = 128,
  parameter int unsigned CNT_W        = 16,
  parameter bit          CLR_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic in_fire_s;
  logic out_fire_s;

  // Handshake outputs decode registered state only.
  assign out_valid  = (state_q != ST_EMPTY);
  assign in_ready   = (state_q != ST_FULL);
  assign out_data   = main_q;
  assign occupancy  = occ_of(state_q);
  assign stall_cnt  = cnt_q;
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;

  // Next-state, payload movement and stall statistics.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;

    if (flush) begin
      // Same-cycle in_fire payload is dropped; out_fire already happened.
      state_d = ST_EMPTY;
      if (CLR_ON_FLUSH) begin
        main_d = {DATA_W{1'b0}};
        skid_d = {DATA_W{1'b0}};
      end else begin
        main_d = main_q;
        skid_d = skid_q;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_d = in_data;
          end else if (in_fire_s) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (out_fire_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end

    // Counter ignores flush; saturates rather than wrapping.
    if (out_valid && !out_ready && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, payload and counter registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_EMPTY;
      main_q  <= {DATA_W{1'b0}};
      skid_q  <= {DATA_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
